// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback queue.
package rf_pkg;

  localparam int NUM_REGS  = 14;
  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = 4;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

  // Indices 14 and 15 do not name a real register.
  function automatic logic is_valid_reg(input logic [REG_IDX_W-1:0] r);
    return r < REG_IDX_W'(NUM_REGS);
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular storage for pending writeback entries; exposes the raw slots and
// read pointer so the top can search the queue by age.
import rf_pkg::*;

module rf_wb_fifo #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full,
  output wb_entry_t [DEPTH-1:0] entries,
  output logic [PW-1:0]         rd_ptr
);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]         wr_ptr;

  // Storage needs no reset: count gates every read of a slot.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head    = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign entries = mem;

endmodule

// File: rtl/rf_writeback.sv
// Writeback buffer in front of the register-file write port, with a pending
// lookup. Define RF_WB_BYPASS_EN to let an empty queue pass a result straight through.
import rf_pkg::*;

module rf_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [REG_IDX_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 drain_hold,
  output logic                 rf_write_reg,
  output logic [REG_IDX_W-1:0] rf_reg_in,
  output logic [DATA_W-1:0]    rf_write_data,
  input  logic [REG_IDX_W-1:0] lookup_reg,
  output logic                 lookup_hit,
  output logic [DATA_W-1:0]    lookup_data,
  output logic [CNT_W-1:0]     pending_count,
  output logic                 bad_reg
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t             head;
  wb_entry_t             offered;
  wb_entry_t [DEPTH-1:0] entries;
  logic [PW-1:0]         rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  empty;
  logic                  full;
  logic                  accept;
  logic                  bypass;
  logic                  push;
  logic                  pop;
  logic [PW-1:0]         slot;

  assign offered  = '{idx: wb_reg, data: wb_data};
  assign wb_ready = !reset && !full;
  assign accept   = wb_valid && wb_ready;

`ifdef RF_WB_BYPASS_EN
  assign bypass = !reset && empty && !drain_hold && wb_valid && is_valid_reg(wb_reg);
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && is_valid_reg(wb_reg) && !bypass;
  assign pop  = !reset && !empty && !drain_hold;

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (offered),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .entries    (entries),
    .rd_ptr     (rd_ptr)
  );

  always_comb begin
    rf_write_reg  = 1'b0;
    rf_reg_in     = '0;
    rf_write_data = '0;
    if (bypass) begin
      rf_write_reg  = 1'b1;
      rf_reg_in     = wb_reg;
      rf_write_data = wb_data;
    end else if (!empty) begin
      rf_write_reg  = pop;
      rf_reg_in     = head.idx;
      rf_write_data = head.data;
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    slot        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr + PW'(i);
      if (!reset && (CNT_W'(i) < count) && (entries[slot].idx == lookup_reg)) begin
        lookup_hit  = 1'b1;
        lookup_data = entries[slot].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bad_reg <= 1'b0;
    end else if (accept && !is_valid_reg(wb_reg)) begin
      bad_reg <= 1'b1;
    end
  end

  assign pending_count = count;

endmodule

// File: doc/rf_writeback.md
RF_WRITEBACK -- requirements
Module: rf_writeback

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of pending write entries (power of two, 2..8).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 wb_valid  in  1  producer offers a write result.
REQ-005 wb_ready  out  1  block can accept the offered result.
REQ-006 wb_reg  in  4  destination register index.
REQ-007 wb_data  in  8  destination register value.
REQ-008 drain_hold  in  1  forbids driving the register-file write port this cycle.
REQ-009 rf_write_reg  out  1  write strobe to register file.
REQ-010 rf_reg_in  out  4  register index to register file.
REQ-011 rf_write_data  out  8  write data to register file.
REQ-012 lookup_reg  in  4  index queried for pending (not yet written) value.
REQ-013 lookup_hit  out  1  a pending entry targets lookup_reg.
REQ-014 lookup_data  out  8  value of youngest pending entry for lookup_reg.
REQ-015 pending_count  out  4  number of queued entries.
REQ-016 bad_reg  out  1  sticky flag: a result targeted index 14 or 15.

Function
REQ-017 Transfer SHALL occur on a rising edge where wb_valid and wb_ready are both 1.
REQ-018 wb_ready SHALL be 1 exactly when pending_count < DEPTH and reset is 0; a pop in the same cycle SHALL NOT make a full queue ready.
REQ-019 A transferred entry with wb_reg <= 13 SHALL be enqueued in FIFO order; wb_reg 14 or 15 SHALL complete the handshake, not be enqueued, and set bad_reg.
REQ-020 rf_write_reg SHALL be 1 exactly when the queue is non-empty and drain_hold is 0; rf_reg_in/rf_write_data SHALL show the head entry (0 when empty).
REQ-021 The head entry SHALL be popped on each edge where rf_write_reg is 1; at most one write per cycle.
REQ-022 Simultaneous push and pop SHALL leave pending_count unchanged and preserve order.
REQ-023 Latency (macro absent): entry accepted at edge N SHALL appear on the write port no earlier than the cycle after edge N.
REQ-024 Same-index entries SHALL be written in arrival order; no coalescing.
REQ-025 lookup_hit/lookup_data SHALL be combinational over queued entries only, youngest match winning; the entry being offered on wb_* SHALL NOT be considered; no match gives lookup_data 0.
REQ-026 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-027 While reset is 1: pending_count, pointers, bad_reg, rf_write_reg, wb_ready, lookup_hit SHALL be 0 at the next edge and while asserted; queue contents are discarded.
REQ-028 Reset asserted with entries pending SHALL drop them with no further rf_write_reg pulses.

Configuration
REQ-029 Macro RF_WB_BYPASS_EN defined: when the queue is empty, drain_hold is 0 and wb_valid is 1 with valid index, the entry SHALL drive the write port combinationally in the same cycle and SHALL NOT be enqueued.
REQ-030 Macro absent: no combinational path from wb_* to rf_* outputs; REQ-023 applies.

Structure
REQ-031 Package rf_pkg SHALL hold NUM_REGS=14, REG_IDX_W=4, DATA_W=8 and typedef wb_entry_t {reg index, data}.
REQ-032 Storage and pointers SHALL live in sub-module rf_wb_fifo; lookup, drop logic and bypass in the top.

Verification
REQ-033 Push r3=0x5A, drain_hold=0 -> rf_write_reg=1 with rf_reg_in=3, rf_write_data=0x5A next cycle (bypass: same cycle), pending_count returns 0.
REQ-034 drain_hold=1, push 5 entries (DEPTH=4) -> wb_ready=0 after 4, pending_count=4; release -> 4 writes in order on consecutive cycles.
REQ-035 Queue r2=0x11 then r2=0x22, hold asserted, lookup_reg=2 -> lookup_hit=1, lookup_data=0x22; lookup_reg=7 -> hit 0, data 0.
REQ-036 Push r15=0xFF -> handshake completes, no rf write, bad_reg=1 until reset.
REQ-037 Assert reset with 3 entries pending -> next cycle pending_count=0, rf_write_reg=0, wb_ready=0; deassert -> wb_ready=1.
REQ-038 Continuous push every cycle with drain_hold=0 for 20 cycles -> pending_count <= 1, all 20 writes in order, pointer wrap exercised.
